render_pixel_collector: RTL and testbench
=========================================

Name: render_pixel_collector

Overview:
- Consumer end of the rendering engine's output handshake.
- Waits for `ready`, pulses `send_data`, then captures the SET_SIZE iteration words that stream back on `data`.
- Maps each word to an 8-bit pixel and writes it to frame memory at a running pixel address.
- When the frame completes, pulses `clear_frame` back to the engine and flags `frame_done` to the display side.

Parameters:
- SET_SIZE, 1, words returned per `send_data` request (matches engine point-unit count).
- HBI, 32, width of an iteration word.
- MAX_ITER, 255, iteration value treated as "in set".
- ADDR_W, 21, pixel address / count width (covers 1280x1024).

Ports:
- CLK  in  1  system clock.
- SYS_RESET_N  in  1  synchronous active-low reset.
- enable  in  1  allow new requests; low holds collector in IDLE after the current burst.
- total_pixels  in  ADDR_W  pixels per frame for the current resolution; sampled in IDLE only.
- ready  in  1  engine has a burst available.
- data  in  HBI  iteration word from engine.
- frame_ready  in  1  engine reports frame fully emitted.
- send_data  out  1  one-cycle burst request.
- clear_frame  out  1  one-cycle acknowledge of frame_ready.
- mem_we  out  1  frame memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_din  out  8  pixel value.
- pixel_count  out  ADDR_W  pixels written this frame.
- frame_done  out  1  one-cycle pulse at frame completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (SYS_RESET_N low at a CLK edge) takes priority over everything, including mid-burst.
  - Outputs after reset: `send_data`=0, `clear_frame`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `pixel_count`=0, `frame_done`=0, `busy`=0.
  - State returns to IDLE; a partially captured burst is discarded.
- Engine timing:
  - `send_data` is sampled high at edge E0.
  - Word k (k = 0..SET_SIZE-1) is valid on `data` between E(k) and E(k+1) and is sampled at E(k+1).
  - `ready` falls after E0.
- IDLE:
  - If `frame_ready` and `pixel_count` >= latched total → FRAME_END.
  - Else if `enable` and `ready` → REQ.
  - FRAME_END check has priority when both conditions hold.
  - `total_pixels` is latched here.
- REQ:
  - `send_data`=1 for exactly this cycle.
  - Word index is cleared; next state is CAPTURE.
- CAPTURE:
  - Each cycle samples `data` and registers `mem_we`=1, `mem_addr`=`pixel_count`, `mem_din`=colour(`data`).
  - `pixel_count` increments; word index increments.
  - After SET_SIZE words → IDLE.
  - Write latency is 1 cycle after the word is sampled.
- Writes past the frame:
  - If `pixel_count` reaches the latched total mid-burst, the remaining words of that burst are dropped (`mem_we`=0).
  - They are still consumed, so the word index advances.
- FRAME_END:
  - `clear_frame`=1 and `frame_done`=1 for one cycle; `pixel_count` ← 0.
  - Then WAIT_CLR: stay until `frame_ready`=0, then → IDLE.
  - This guarantees a single acknowledge per frame.
- colour(d), computed on the full HBI bits:
  - `d` >= MAX_ITER → 8'h00 (black).
  - Otherwise `d[7:0]`.
- `pixel_count` wraps never. The frame limit holds it at `total_pixels`; `mem_addr` never exceeds `total_pixels`-1.
- `enable` dropping during REQ/CAPTURE: the burst completes, then the block idles.
- `ready` while in CAPTURE or WAIT_CLR is ignored.

Optional Feature:
- Macro: RENDER_COLLECTOR_PEAK_EN.
- Defined:
  - Adds output `peak_iter[7:0]`, reset 0.
  - Each written word with `d` < MAX_ITER and `d[7:0]` > `peak_iter` updates it on the same edge as the write.
  - Cleared in FRAME_END.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package `render_collector_pkg`:
  - State enum {IDLE, REQ, CAPTURE, FRAME_END, WAIT_CLR}.
  - COLOUR_IN_SET = 8'h00.
  - ADDR_W default constant.
- Sub-module `iter_to_colour`: purely combinational mapping, parameters HBI and MAX_ITER. Reused later by palette work.

Test Plan:
- Reset mid-CAPTURE (SET_SIZE=4, after 2 words) → next edge all outputs 0, state IDLE, no further `mem_we`.
- SET_SIZE=1, `ready`=1, `data`=17 one cycle after `send_data` → `send_data` high exactly 1 cycle; `mem_we` at address 0 with `mem_din`=8'h11; `pixel_count`=1.
- SET_SIZE=4, words 3, 255, 300, 254 → `mem_din` = 03, 00, 00, FE at addresses n..n+3.
- `total_pixels`=6, SET_SIZE=4, two bursts → only 6 writes (addresses 0–5); last 2 words dropped; `pixel_count`=6.
- `frame_ready` high for 5 cycles after count=6 → exactly one `clear_frame`/`frame_done` pulse; `pixel_count`=0; IDLE only after `frame_ready` falls.
- `enable`=0 with `ready`=1 → `send_data` never asserts, `busy`=0. With RENDER_COLLECTOR_PEAK_EN, words 9, 255, 40 → `peak_iter`=40.

Source files
------------

// File: rtl/render_collector_pkg.sv
// render_collector_pkg: shared state encoding and constants for the pixel collector.
// Revision 1.0
`default_nettype none

package render_collector_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    CAPTURE   = 3'd2,
    FRAME_END = 3'd3,
    WAIT_CLR  = 3'd4
  } state_t;

  localparam logic [7:0] COLOUR_IN_SET  = 8'h00;
  localparam int         ADDR_W_DEFAULT = 21;

endpackage

`default_nettype wire

// File: rtl/iter_to_colour.sv
// iter_to_colour: maps an iteration count to an 8-bit pixel; in-set points are black.
// Revision 1.0
`default_nettype none

module iter_to_colour
  import render_collector_pkg::*;
#(
  parameter int HBI      = 32,
  parameter int MAX_ITER = 255
) (
  input  logic [HBI-1:0] iter,
  output logic [7:0]     colour
);

  always_comb begin
    colour = (iter >= HBI'(MAX_ITER)) ? COLOUR_IN_SET : iter[7:0];
  end

endmodule

`default_nettype wire

// File: rtl/render_pixel_collector.sv
// render_pixel_collector: requests bursts from the render engine and writes pixels to frame memory.
// Optional peak tracking under RENDER_COLLECTOR_PEAK_EN. Revision 1.0
`default_nettype none

module render_pixel_collector
  import render_collector_pkg::*;
#(
  parameter int SET_SIZE = 1,
  parameter int HBI      = 32,
  parameter int MAX_ITER = 255,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              SYS_RESET_N,
  input  logic              enable,
  input  logic [ADDR_W-1:0] total_pixels,
  input  logic              ready,
  input  logic [HBI-1:0]    data,
  input  logic              frame_ready,
  output logic              send_data,
  output logic              clear_frame,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              frame_done,
`ifdef RENDER_COLLECTOR_PEAK_EN
  output logic              busy,
  output logic [7:0]        peak_iter
`else
  output logic              busy
`endif
);

  localparam int IDX_W = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

  state_t            state, next_state;
  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] total_latched;
  logic [7:0]        colour;
  logic              last_word;

  iter_to_colour #(
    .HBI      (HBI),
    .MAX_ITER (MAX_ITER)
  ) u_colour (
    .iter   (data),
    .colour (colour)
  );

  assign last_word = (word_idx == IDX_W'(SET_SIZE - 1));

  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state  = state;
    send_data   = 1'b0;
    clear_frame = 1'b0;
    frame_done  = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // The limit is compared against the live input because IDLE is where it is latched.
        if (frame_ready && (pixel_count >= total_pixels)) next_state = FRAME_END;
        else if (enable && ready)                         next_state = REQ;
      end
      REQ: begin
        send_data  = 1'b1;
        next_state = CAPTURE;
      end
      CAPTURE: begin
        if (last_word) next_state = IDLE;
      end
      FRAME_END: begin
        clear_frame = 1'b1;
        frame_done  = 1'b1;
        next_state  = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!frame_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= 8'h00;
      pixel_count   <= '0;
      word_idx      <= '0;
      total_latched <= '0;
`ifdef RENDER_COLLECTOR_PEAK_EN
      peak_iter     <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE:    total_latched <= total_pixels;
        REQ:     word_idx      <= '0;
        CAPTURE: begin
          word_idx <= word_idx + 1'b1;
          // Words beyond the frame limit are consumed but not written.
          if (pixel_count < total_latched) begin
            mem_we      <= 1'b1;
            mem_addr    <= pixel_count;
            mem_din     <= colour;
            pixel_count <= pixel_count + 1'b1;
`ifdef RENDER_COLLECTOR_PEAK_EN
            if (colour > peak_iter) peak_iter <= colour;
`endif
          end
        end
        FRAME_END: begin
          pixel_count <= '0;
`ifdef RENDER_COLLECTOR_PEAK_EN
          peak_iter   <= 8'h00;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_render_pixel_collector.sv
// tb_render_pixel_collector: engine model, reference scoreboard and directed/random frames.
`default_nettype none

module tb_render_pixel_collector;

  localparam int SET_SIZE = 4;
  localparam int HBI      = 32;
  localparam int MAX_ITER = 255;
  localparam int ADDR_W   = 21;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [ADDR_W-1:0] total_pixels;
  logic              ready;
  logic [HBI-1:0]    data;
  logic              frame_ready;
  logic              send_data, clear_frame, mem_we, frame_done, busy;
  logic [ADDR_W-1:0] mem_addr, pixel_count;
  logic [7:0]        mem_din;
`ifdef RENDER_COLLECTOR_PEAK_EN
  logic [7:0]        peak_iter;
`endif

  always #5 clk = ~clk;

  render_pixel_collector #(
    .SET_SIZE (SET_SIZE),
    .HBI      (HBI),
    .MAX_ITER (MAX_ITER),
    .ADDR_W   (ADDR_W)
  ) dut (
    .CLK          (clk),
    .SYS_RESET_N  (rst_n),
    .enable       (enable),
    .total_pixels (total_pixels),
    .ready        (ready),
    .data         (data),
    .frame_ready  (frame_ready),
    .send_data    (send_data),
    .clear_frame  (clear_frame),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .pixel_count  (pixel_count),
    .frame_done   (frame_done),
`ifdef RENDER_COLLECTOR_PEAK_EN
    .busy         (busy),
    .peak_iter    (peak_iter)
`else
    .busy         (busy)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  model_count = 0;
  int  model_total = 0;
  int  clear_cnt = 0;
  int  done_cnt  = 0;

  function automatic logic [7:0] ref_colour(input logic [31:0] d);
    return (d >= 32'(MAX_ITER)) ? 8'h00 : d[7:0];
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(250, 260));
      1:       return $urandom;
      default: return 32'($urandom_range(0, 254));
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send_data"},   64'(send_data),   64'd0);
    check({tag, "_clear_frame"}, 64'(clear_frame), 64'd0);
    check({tag, "_mem_we"},      64'(mem_we),      64'd0);
    check({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
    check({tag, "_mem_din"},     64'(mem_din),     64'd0);
    check({tag, "_pixel_count"}, 64'(pixel_count), 64'd0);
    check({tag, "_frame_done"},  64'(frame_done),  64'd0);
    check({tag, "_busy"},        64'(busy),        64'd0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (clear_frame === 1'b1) clear_cnt++;
    if (frame_done === 1'b1)  done_cnt++;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d din 0x%0h with none expected", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_din",  64'(mem_din),  64'(e.din));
      end
    end
  end

  // Engine model: offers a burst, answers send_data with SET_SIZE words.
  // abort_after < SET_SIZE asserts reset once that many words have been sampled.
  task automatic burst(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3, input int abort_after);
    logic [31:0] w[4];
    int t;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    ready = 1'b1;
    t = 0;
    while (send_data !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (send_data !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_data_timeout: got 0 after %0d cycles, expected 1", t);
      ready = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
    data  = w[0];
    @(negedge clk);
    check("send_data_one_cycle", 64'(send_data), 64'd0);
    check("busy_in_capture",     64'(busy),      64'd1);
    for (int k = 0; k < SET_SIZE; k++) begin
      if (k == abort_after) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_capture");
        rst_n = 1'b1;
        model_count = 0;
        return;
      end
      if (model_count < model_total) begin
        exp_q.push_back('{addr: ADDR_W'(model_count), din: ref_colour(w[k])});
        model_count++;
      end
      @(posedge clk);
      #1;
      data = (k + 1 < SET_SIZE) ? w[k + 1] : $urandom;
    end
  endtask

  task automatic frame_end_seq();
    clear_cnt   = 0;
    done_cnt    = 0;
    frame_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_clr_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_frame_pulses", 64'(clear_cnt),   64'd1);
    check("frame_done_pulses",  64'(done_cnt),    64'd1);
    check("idle_after_clear",   64'(busy),        64'd0);
    check("count_after_frame",  64'(pixel_count), 64'd0);
    model_count = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sends;
    rst_n        = 1'b0;
    enable       = 1'b1;
    ready        = 1'b0;
    data         = '0;
    frame_ready  = 1'b0;
    total_pixels = ADDR_W'(6);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n       = 1'b1;
    model_total = 6;
    model_count = 0;
    @(posedge clk);
    #1;

    // Reset after two words of a burst: only those two are written.
    burst(32'd3, 32'd255, 32'd300, 32'd254, 2);
    repeat (4) @(posedge clk);
    #1;
    check("no_writes_after_reset", 64'(exp_q.size()), 64'd0);

    // Colour mapping, then a burst that overruns the 6-pixel frame.
    burst(32'd3, 32'd255, 32'd300, 32'd254, SET_SIZE);
    check("count_after_burst1", 64'(pixel_count), 64'd4);
    burst(32'd17, 32'd254, 32'd5, 32'd6, SET_SIZE);
    check("count_capped", 64'(pixel_count), 64'd6);
    check("busy_after_burst", 64'(busy), 64'd0);
    frame_end_seq();

    // enable low: requests are ignored.
    enable = 1'b0;
    ready  = 1'b1;
    sends  = 0;
    repeat (10) begin
      @(negedge clk);
      if (send_data === 1'b1) sends++;
    end
    check("disabled_send_data", 64'(sends), 64'd0);
    check("disabled_busy",      64'(busy),  64'd0);
    ready  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Random frames of random size.
    repeat (4) begin
      model_total  = $urandom_range(5, 14);
      model_count  = 0;
      total_pixels = ADDR_W'(model_total);
      while (model_count < model_total)
        burst(rand_word(), rand_word(), rand_word(), rand_word(), SET_SIZE);
      check("random_frame_count", 64'(pixel_count), 64'(model_total));
      frame_end_seq();
    end

`ifdef RENDER_COLLECTOR_PEAK_EN
    check("peak_cleared", 64'(peak_iter), 64'd0);
    model_total  = 20;
    total_pixels = ADDR_W'(20);
    burst(32'd9, 32'd255, 32'd40, 32'd1, SET_SIZE);
    check("peak_value", 64'(peak_iter), 64'd40);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
